histogram_bar_renderer: RTL and testbench

Parametrised successor to the single-channel histogram displayer. It converts a raster scan position (X, Y) into an RGB pixel that draws an NCH-channel histogram as vertical bars inside a configurable plot window. Bars are scaled against a runtime maximum and an optional threshold marker column is overlaid. It sits between the histogram bin RAM (synchronous read, one-cycle latency) and the LCD pixel mux, and has a fixed pipeline latency.

---
 rtl/histogram_bar_renderer_if.sv | 24 ++
 rtl/histogram_bar_renderer.sv | 137 +++++++++++++
 tb/tb_histogram_bar_renderer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_bar_renderer_if.sv
// Raster pixel stream: scan position in, rendered pixel colour out.
// Shared by the bar renderer and whatever drives the scan.
interface histogram_bar_renderer_if #(
    parameter int unsigned XY_W = 11
);
    logic            iValid;
    logic [XY_W-1:0] X_Cont;
    logic [XY_W-1:0] Y_Cont;
    logic            oValid;
    logic [7:0]      oRed;
    logic [7:0]      oGreen;
    logic [7:0]      oBlue;
    logic [7:0]      oPixel;

    modport master (
        output iValid, X_Cont, Y_Cont,
        input  oValid, oRed, oGreen, oBlue, oPixel
    );

    modport slave (
        input  iValid, X_Cont, Y_Cont,
        output oValid, oRed, oGreen, oBlue, oPixel
    );
endinterface

// File: rtl/histogram_bar_renderer.sv
// Renders an NCH-channel histogram as vertical bars in a plot window.
// Fixed 3-cycle pipeline around a 1-cycle-latency bin RAM read.
module histogram_bar_renderer #(
    parameter int unsigned NCH     = 1,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned VAL_W   = 20,
    parameter int unsigned X_ORG   = 16,
    parameter int unsigned Y_ORG   = 40,
    parameter int unsigned BIN_PIX = 3,
    parameter int unsigned PLOT_H  = 400,
    parameter int unsigned XY_W    = 11
) (
    input  logic                     iClk,
    input  logic                     iRst,
    histogram_bar_renderer_if.slave  pix,
    input  logic [NCH*VAL_W-1:0]     iHistoValue,
    input  logic [VAL_W-1:0]         iMaxValue,
    input  logic                     iMarkerEn,
    input  logic [ADDR_W-1:0]        iThreshBin,
    output logic [ADDR_W-1:0]        oHistoAddr
);
    localparam int unsigned X_END = X_ORG + BIN_PIX * (2 ** ADDR_W);
    localparam int unsigned Y_END = Y_ORG + PLOT_H;
    localparam int unsigned H_W   = (PLOT_H > 1) ? $clog2(PLOT_H) : 1;
    localparam int unsigned P_W   = VAL_W + $clog2(PLOT_H + 1);

    logic [XY_W-1:0]   x_in, y_in;
    logic [31:0]       x32, y32;
    logic              in_plot;
    logic [ADDR_W-1:0] bin;
    logic [2:0]        lit;

    // Stage 1: geometry
    logic v1_q, v1_d, in1_q, in1_d, mk1_q, mk1_d;
    logic [H_W-1:0]    h1_q, h1_d;
    logic [VAL_W-1:0]  max1_q, max1_d;
    logic [ADDR_W-1:0] histo_addr_q, histo_addr_d;
    // RAM wait stage
    logic v2_q, v2_d, in2_q, in2_d, mk2_q, mk2_d;
    logic [H_W-1:0]    h2_q, h2_d;
    logic [VAL_W-1:0]  max2_q, max2_d;
    // Stage 2: products
    logic v3_q, v3_d, in3_q, in3_d, mk3_q, mk3_d, mz3_q, mz3_d;
    logic [NCH-1:0][P_W-1:0] vp3_q, vp3_d;
    logic [P_W-1:0]          hm3_q, hm3_d;
    // Stage 3: colour
    logic       valid_q, valid_d;
    logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d, pixel_q, pixel_d;

    always_comb begin
        x_in    = pix.X_Cont;
        y_in    = pix.Y_Cont;
        x32     = 32'(x_in);
        y32     = 32'(y_in);
        in_plot = (x32 >= X_ORG) && (x32 < X_END) && (y32 >= Y_ORG) && (y32 < Y_END);
        bin     = ADDR_W'((x32 - X_ORG) / BIN_PIX);

        v1_d         = pix.iValid;
        in1_d        = in_plot;
        histo_addr_d = in_plot ? bin : '0;
        h1_d         = in_plot ? H_W'((Y_END - 1) - y32) : '0;
        mk1_d        = iMarkerEn && in_plot && (bin == iThreshBin);
        max1_d       = iMaxValue;

        v2_d   = v1_q;
        in2_d  = in1_q;
        mk2_d  = mk1_q;
        h2_d   = h1_q;
        max2_d = max1_q;

        // Full-width products: v*PLOT_H > h*max is the ceil-height test without division
        v3_d  = v2_q;
        in3_d = in2_q;
        mk3_d = mk2_q;
        mz3_d = (max2_q == '0);
        vp3_d = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            vp3_d[c] = P_W'(iHistoValue[c*VAL_W +: VAL_W]) * P_W'(PLOT_H);
        end
        hm3_d = P_W'(h2_q) * P_W'(max2_q);

        lit = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            lit[c] = in3_q && !mz3_q && (vp3_q[c] > hm3_q);
        end

        valid_d = v3_q;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        pixel_d = '0;
        if (v3_q) begin
            if (mk3_q) begin
                red_d   = '1;
                pixel_d = 8'h80;
            end else if (NCH == 1) begin
                if (lit[0]) begin
                    red_d   = '1;
                    green_d = '1;
                    blue_d  = '1;
                    pixel_d = '1;
                end
            end else begin
                red_d   = {8{lit[0]}};
                green_d = {8{lit[1]}};
                blue_d  = {8{lit[2]}};
                pixel_d = (|lit) ? 8'hFF : 8'h00;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v1_q <= '0; in1_q <= '0; mk1_q <= '0; h1_q <= '0; max1_q <= '0;
            histo_addr_q <= '0;
            v2_q <= '0; in2_q <= '0; mk2_q <= '0; h2_q <= '0; max2_q <= '0;
            v3_q <= '0; in3_q <= '0; mk3_q <= '0; mz3_q <= '0;
            vp3_q <= '0; hm3_q <= '0;
            valid_q <= '0; red_q <= '0; green_q <= '0; blue_q <= '0; pixel_q <= '0;
        end else begin
            v1_q <= v1_d; in1_q <= in1_d; mk1_q <= mk1_d; h1_q <= h1_d; max1_q <= max1_d;
            histo_addr_q <= histo_addr_d;
            v2_q <= v2_d; in2_q <= in2_d; mk2_q <= mk2_d; h2_q <= h2_d; max2_q <= max2_d;
            v3_q <= v3_d; in3_q <= in3_d; mk3_q <= mk3_d; mz3_q <= mz3_d;
            vp3_q <= vp3_d; hm3_q <= hm3_d;
            valid_q <= valid_d; red_q <= red_d; green_q <= green_d; blue_q <= blue_d;
            pixel_q <= pixel_d;
        end
    end

    assign oHistoAddr = histo_addr_q;
    assign pix.oValid = valid_q;
    assign pix.oRed   = red_q;
    assign pix.oGreen = green_q;
    assign pix.oBlue  = blue_q;
    assign pix.oPixel = pixel_q;
endmodule

// File: tb/tb_histogram_bar_renderer.sv
// Bench for histogram_bar_renderer: NCH=1 and NCH=3 instances fed the same scan,
// checked against a ceil-height reference model and a hand-written vector table.
module tb_histogram_bar_renderer;
    typedef struct packed {
        logic       v;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] p;
    } out_t;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] pix;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [19:0] max_v;
    logic        mk_en;
    logic [7:0]  thresh;
    logic [7:0]  addr1, addr3;
    logic [19:0] rd1;
    logic [59:0] rd3;
    logic [19:0] bins1 [256];
    logic [19:0] bins3 [256][3];

    int errors = 0;
    int checks = 0;
    out_t q1[$];
    out_t q3[$];

    histogram_bar_renderer_if #(.XY_W(11)) pif1();
    histogram_bar_renderer_if #(.XY_W(11)) pif3();

    histogram_bar_renderer #(.NCH(1)) u_dut1 (
        .iClk(clk), .iRst(rst), .pix(pif1), .iHistoValue(rd1), .iMaxValue(max_v),
        .iMarkerEn(mk_en), .iThreshBin(thresh), .oHistoAddr(addr1)
    );

    histogram_bar_renderer #(.NCH(3)) u_dut3 (
        .iClk(clk), .iRst(rst), .pix(pif3), .iHistoValue(rd3), .iMaxValue(max_v),
        .iMarkerEn(mk_en), .iThreshBin(thresh), .oHistoAddr(addr3)
    );

    // Bin RAM with one-cycle synchronous read
    always @(posedge clk) begin
        rd1 <= bins1[addr1];
        rd3 <= {bins3[addr3][2], bins3[addr3][1], bins3[addr3][0]};
    end

    function automatic bit bar_lit(input longint v, input longint mx, input int h);
        if (mx == 0 || v == 0) return 1'b0;
        return longint'(h) < (v * 400 + mx - 1) / mx;
    endfunction

    function automatic bit in_plot(input int x, input int y);
        return x >= 16 && x < 784 && y >= 40 && y < 440;
    endfunction

    function automatic out_t model(input int nch, input logic v, input int x, input int y,
                                   input logic [19:0] mx, input logic men, input logic [7:0] th);
        out_t o = '0;
        int bin, h;
        if (!v) return o;
        o.v = 1'b1;
        if (!in_plot(x, y)) return o;
        bin = (x - 16) / 3;
        h   = 439 - y;
        if (men && bin == int'(th)) begin
            o.r = 8'hFF;
            o.p = 8'h80;
            return o;
        end
        if (nch == 1) begin
            if (bar_lit(longint'(bins1[bin]), longint'(mx), h)) begin
                o.r = 8'hFF; o.g = 8'hFF; o.b = 8'hFF; o.p = 8'hFF;
            end
        end else begin
            o.r = bar_lit(longint'(bins3[bin][0]), longint'(mx), h) ? 8'hFF : 8'h00;
            o.g = bar_lit(longint'(bins3[bin][1]), longint'(mx), h) ? 8'hFF : 8'h00;
            o.b = bar_lit(longint'(bins3[bin][2]), longint'(mx), h) ? 8'hFF : 8'h00;
            o.p = (o.r != 0 || o.g != 0 || o.b != 0) ? 8'hFF : 8'h00;
        end
        return o;
    endfunction

    task automatic chk_out(input string nm, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t act v=%b rgb=%h_%h_%h pix=%h exp v=%b rgb=%h_%h_%h pix=%h",
                     nm, $time, a.v, a.r, a.g, a.b, a.p, e.v, e.r, e.g, e.b, e.p);
        end
    endtask

    task automatic chk_addr(input string nm, input logic [7:0] a, input int e);
        checks++;
        if (a !== 8'(e)) begin
            errors++;
            $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, a, e);
        end
    endtask

    // One clock: drive a pixel, advance, compare the output leaving the pipe
    task automatic step(input logic v, input int x, input int y, input logic r,
                        input bit use_tbl, input logic [7:0] tpix);
        out_t e1, e3, a1, a3;
        int   ea;
        rst = r;
        pif1.iValid = v; pif1.X_Cont = 11'(x); pif1.Y_Cont = 11'(y);
        pif3.iValid = v; pif3.X_Cont = 11'(x); pif3.Y_Cont = 11'(y);
        e1 = use_tbl ? out_t'{v: 1'b1, r: tpix, g: tpix, b: tpix, p: tpix}
                     : model(1, v, x, y, max_v, mk_en, thresh);
        e3 = model(3, v, x, y, max_v, mk_en, thresh);
        ea = in_plot(x, y) ? (x - 16) / 3 : 0;
        @(posedge clk);
        #1;
        if (r) begin
            q1.delete(); q3.delete();
            repeat (4) begin q1.push_back('0); q3.push_back('0); end
            ea = 0;
        end else begin
            q1.push_back(e1); q3.push_back(e3);
        end
        a1 = {pif1.oValid, pif1.oRed, pif1.oGreen, pif1.oBlue, pif1.oPixel};
        a3 = {pif3.oValid, pif3.oRed, pif3.oGreen, pif3.oBlue, pif3.oPixel};
        if (q1.size() > 0) chk_out("pix1", a1, q1.pop_front());
        if (q3.size() > 0) chk_out("pix3", a3, q3.pop_front());
        if (v || r) begin
            chk_addr("addr1", addr1, ea);
            chk_addr("addr3", addr3, ea);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic scan_row(input int y);
        for (int x = 0; x < 800; x++) step(1'b1, x, y, 1'b0, 1'b0, 8'h00);
        idle(2);
    endtask

    vec_t tbl[13];
    int   rows_a[10] = '{0, 39, 40, 41, 239, 240, 438, 439, 440, 479};
    int   rows_m[6]  = '{39, 40, 200, 300, 439, 440};

    initial begin
        tbl[0]  = '{30, 439, 8'h00};
        tbl[1]  = '{31, 439, 8'hFF};
        tbl[2]  = '{33, 439, 8'hFF};
        tbl[3]  = '{34, 439, 8'h00};
        tbl[4]  = '{31, 340, 8'hFF};
        tbl[5]  = '{31, 339, 8'h00};
        tbl[6]  = '{33, 340, 8'hFF};
        tbl[7]  = '{33, 339, 8'h00};
        tbl[8]  = '{32,  40, 8'h00};
        tbl[9]  = '{32, 440, 8'h00};
        tbl[10] = '{15, 439, 8'h00};
        tbl[11] = '{100, 439, 8'h00};
        tbl[12] = '{784, 439, 8'h00};

        rst = 1'b1; max_v = '0; mk_en = 1'b0; thresh = '0;
        pif1.iValid = 1'b0; pif1.X_Cont = '0; pif1.Y_Cont = '0;
        pif3.iValid = 1'b0; pif3.X_Cont = '0; pif3.Y_Cont = '0;
        for (int i = 0; i < 256; i++) begin
            bins1[i] = '0; bins3[i][0] = '0; bins3[i][1] = '0; bins3[i][2] = '0;
        end

        repeat (3) step(1'b1, 100, 100, 1'b1, 1'b0, 8'h00);

        // Flat histogram; NCH=3 gets R=max, G=0, B=max/2
        for (int i = 0; i < 256; i++) begin
            bins1[i] = 20'd100; bins3[i][0] = 20'd100; bins3[i][1] = 20'd0; bins3[i][2] = 20'd50;
        end
        max_v = 20'd100;
        idle(2);
        foreach (rows_a[i]) scan_row(rows_a[i]);
        for (int x = 0; x < 200; x++) step(1'($urandom_range(0, 1)), x, 300, 1'b0, 1'b0, 8'h00);
        idle(4);

        // Single bin 5 = 50 against max 200
        for (int i = 0; i < 256; i++) begin
            bins1[i] = '0; bins3[i][0] = '0; bins3[i][1] = '0; bins3[i][2] = '0;
        end
        bins1[5] = 20'd50; bins3[5][1] = 20'd50;
        max_v = 20'd200;
        for (int i = 0; i < 13; i++) step(1'b1, tbl[i].x, tbl[i].y, 1'b0, 1'b1, tbl[i].pix);
        idle(2);
        scan_row(339); scan_row(340);
        idle(4);

        // Zero scale, then 2x over-range and near-max values
        for (int i = 0; i < 256; i++) begin
            bins1[i] = 20'd300; bins3[i][0] = 20'd300; bins3[i][1] = 20'd1; bins3[i][2] = 20'hFFFFF;
        end
        max_v = 20'd0;
        idle(2);
        scan_row(40); scan_row(439);
        idle(4);
        for (int i = 0; i < 256; i++) bins1[i] = 20'd200;
        max_v = 20'd100;
        idle(2);
        scan_row(39); scan_row(40); scan_row(439);
        max_v = 20'hFFFFF;
        scan_row(40); scan_row(438);
        idle(4);

        // Threshold marker on bin 128, enabled then disabled
        for (int i = 0; i < 256; i++) begin
            bins1[i] = 20'd100; bins3[i][0] = 20'd100; bins3[i][1] = 20'd0; bins3[i][2] = 20'd50;
        end
        max_v = 20'd100; thresh = 8'd128;
        idle(2);
        for (int e = 1; e >= 0; e--) begin
            mk_en = 1'(e);
            foreach (rows_m[i]) for (int x = 396; x < 407; x++) step(1'b1, x, rows_m[i], 1'b0, 1'b0, 8'h00);
        end
        mk_en = 1'b0;

        // Single-cycle reset in the middle of a valid stream
        for (int x = 0; x < 60; x++) step(1'b1, x + 20, 300, (x == 30), 1'b0, 8'h00);
        idle(4);

        // Randomised pixels, scale, marker and occasional reset
        for (int i = 0; i < 256; i++) begin
            bins1[i] = ($urandom_range(0, 15) == 0) ? 20'($urandom()) : 20'($urandom_range(0, 1200));
            for (int c = 0; c < 3; c++)
                bins3[i][c] = ($urandom_range(0, 15) == 0) ? 20'($urandom()) : 20'($urandom_range(0, 1200));
        end
        idle(2);
        for (int n = 0; n < 3000; n++) begin
            int x, y;
            x = $urandom_range(0, 799);
            y = $urandom_range(0, 479);
            max_v  = ($urandom_range(0, 7) == 0) ? 20'd0 : 20'($urandom_range(1, 1200));
            mk_en  = 1'($urandom_range(0, 1));
            thresh = ($urandom_range(0, 3) == 0 && in_plot(x, y)) ? 8'((x - 16) / 3)
                                                                  : 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 3) != 0), x, y, ($urandom_range(0, 199) == 0), 1'b0, 8'h00);
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
